// File: rtl/seq_pattern_gen_pkg.sv
// seq_pattern_gen shared types.
// FSM states, pass modes and the default pattern length.
package seq_pattern_gen_pkg;

  localparam int MAX_LEN_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  typedef enum logic {
    REPEAT   = 1'b0,
    ONE_SHOT = 1'b1
  } mode_e;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen control/load/stream bundle.
// master drives requests, slave is the generator.
interface seq_pattern_gen_if
  import seq_pattern_gen_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               en;
  logic               mode;
  logic               load_valid;
  logic               load_ready;
  logic [MAX_LEN-1:0] load_pattern;
  logic [LEN_W-1:0]   load_len;
  logic               y;
  logic               y_valid;
  logic               done;

  modport master (
    output en, mode, load_valid,
    output load_pattern, load_len,
    input  load_ready, y, y_valid, done
  );

  modport slave (
    input  en, mode, load_valid,
    input  load_pattern, load_len,
    output load_ready, y, y_valid, done
  );
endinterface

// File: rtl/pattern_idx_counter.sv
// Bit-index counter for the pattern generator.
// Wraps to 0 after len-1; last flags the final bit.
module pattern_idx_counter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] idx,
  output logic             last
);
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] idx_d;

  // next index: advance with wrap at the terminal count
  always_comb begin
    last  = (idx_q == len - LEN_W'(1));
    idx_d = idx_q;
    if (adv) begin
      idx_d = last ? '0 : idx_q + LEN_W'(1);
    end
  end

  // index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  assign idx = idx_q;
endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator, repeat or one-shot.
// Loads accepted in IDLE only; en advances one bit.
module seq_pattern_gen
  import seq_pattern_gen_pkg::*;
#(
  parameter int                 MAX_LEN         = MAX_LEN_DEF,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b1011_0010,
  parameter int                 LEN_W           = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               mode,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [MAX_LEN-1:0] load_pattern,
  input  logic [LEN_W-1:0]   load_len,
  output logic               y,
  output logic               y_valid,
  output logic               done
);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] BIT0 =
    {{(MAX_LEN-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d, run_mode;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d, len_sat;
  logic               y_q, y_d;
  logic               y_valid_q, y_valid_d;
  logic               done_q, done_d;
  logic               is_idle, go, adv, last;
  logic [LEN_W-1:0]   idx;

  pattern_idx_counter #(.LEN_W(LEN_W)) u_idx (
    .clk   (clk),
    .rst_n (reset),
    .adv   (adv),
    .len   (len_q),
    .idx   (idx),
    .last  (last)
  );

  // next-state: load in IDLE, else emit on en, else pause
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    done_d    = 1'b0;
    adv       = 1'b0;
    is_idle   = (state_q == IDLE);
    go        = en && !(is_idle && load_valid);
    run_mode  = is_idle ? mode_e'(mode) : mode_q;
    len_sat   = (load_len == '0 || load_len > MAX_LEN_L)
              ? MAX_LEN_L : load_len;
    if (is_idle && load_valid) begin
      pattern_d = load_pattern;
      len_d     = len_sat;
    end
    if (go) begin
      adv       = 1'b1;
      y_d       = |(pattern_q & (BIT0 << idx));
      y_valid_d = 1'b1;
      done_d    = last;
      if (is_idle) mode_d = run_mode;
      state_d = (last && run_mode == ONE_SHOT) ? IDLE : RUN;
    end else if (!is_idle) begin
      state_d = PAUSE;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mode_q    <= REPEAT;
      pattern_q <= DEFAULT_PATTERN;
      len_q     <= MAX_LEN_L;
      y_q       <= 1'b0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      done_q    <= done_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign y          = y_q;
  assign y_valid    = y_valid_q;
  assign done       = done_q;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen.
// Random and directed stimulus vs a pass-level model.
module tb_seq_pattern_gen;
  localparam int ML = 8;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_pattern_gen_if ifc ();

  seq_pattern_gen dut (
    .clk          (clk),
    .reset        (reset),
    .en           (ifc.en),
    .mode         (ifc.mode),
    .load_valid   (ifc.load_valid),
    .load_ready   (ifc.load_ready),
    .load_pattern (ifc.load_pattern),
    .load_len     (ifc.load_len),
    .y            (ifc.y),
    .y_valid      (ifc.y_valid),
    .done         (ifc.done)
  );

  // model: active pass flag, pattern, length, position
  bit m_run;
  bit m_pat [ML];
  int m_len;
  int m_pos;
  bit m_once;
  bit exp_y, exp_v, exp_d;
  bit dstr [ML];

  task automatic model_reset();
    logic [7:0] d;
    d = 8'b1011_0010;
    for (int i = 0; i < ML; i++) begin
      m_pat[i] = d[i];
      dstr[i]  = d[i];
    end
    m_run = 0; m_len = ML; m_pos = 0; m_once = 0;
    exp_y = 0; exp_v = 0; exp_d = 0;
  endtask

  task automatic idle_inputs();
    ifc.en = 0; ifc.mode = 0; ifc.load_valid = 0;
    ifc.load_pattern = '0; ifc.load_len = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    idle_inputs();
    #1 model_reset();
    @(negedge clk);
    reset = 1;
  endtask

  // one clock edge, model advanced with inputs seen at that edge
  task automatic step();
    int ll;
    @(posedge clk);
    ll = int'(ifc.load_len);
    exp_v = 0; exp_d = 0;
    if (!m_run && ifc.load_valid) begin
      for (int i = 0; i < ML; i++) m_pat[i] = ifc.load_pattern[i];
      m_len = (ll == 0 || ll > ML) ? ML : ll;
    end else if (ifc.en) begin
      if (!m_run) begin
        m_run = 1; m_once = ifc.mode; m_pos = 0;
      end
      exp_y = m_pat[m_pos];
      exp_v = 1;
      if (m_pos == m_len - 1) begin
        exp_d = 1; m_pos = 0;
        if (m_once) m_run = 0;
      end else begin
        m_pos++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    #3 model_reset();
    checks++;
    if ({ifc.y, ifc.y_valid, ifc.done, ifc.load_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_state got=%b exp=0001",
        {ifc.y, ifc.y_valid, ifc.done, ifc.load_ready});
    end
    @(negedge clk);
    reset = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({ifc.y, ifc.y_valid, ifc.done, ifc.load_ready} !==
          {exp_y, exp_v, exp_d, !m_run}) begin
        errors++;
        $display("FAIL reset_idle k=%0d got=%b exp=%b", k,
          {ifc.y, ifc.y_valid, ifc.done, ifc.load_ready},
          {exp_y, exp_v, exp_d, !m_run});
      end
    end
  endtask

  task automatic test_default_stream();
    do_reset();
    ifc.en = 1; ifc.mode = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      checks++;
      if ({ifc.y, ifc.y_valid, ifc.done} !==
          {dstr[k % ML], 1'b1, (k % ML) == ML - 1}) begin
        errors++;
        $display("FAIL default_stream k=%0d got=%b exp=%b", k,
          {ifc.y, ifc.y_valid, ifc.done},
          {dstr[k % ML], 1'b1, (k % ML) == ML - 1});
      end
    end
  endtask

  task automatic test_oneshot_load();
    bit ev [3];
    ev[0] = 1; ev[1] = 0; ev[2] = 1;
    do_reset();
    ifc.load_valid = 1; ifc.load_pattern = 8'h05; ifc.load_len = 4'd3;
    step();
    ifc.load_valid = 0; ifc.en = 1; ifc.mode = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({ifc.y, ifc.y_valid, ifc.done} !== {ev[k], 1'b1, k == 2}) begin
        errors++;
        $display("FAIL oneshot_bits k=%0d got=%b exp=%b", k,
          {ifc.y, ifc.y_valid, ifc.done}, {ev[k], 1'b1, k == 2});
      end
    end
    ifc.en = 0;
    step();
    checks++;
    if ({ifc.y_valid, ifc.done, ifc.load_ready} !== 3'b001) begin
      errors++;
      $display("FAIL oneshot_end got=%b exp=001",
        {ifc.y_valid, ifc.done, ifc.load_ready});
    end
  endtask

  task automatic test_pause();
    do_reset();
    ifc.en = 1; ifc.mode = 0;
    for (int k = 0; k < 3; k++) step();
    ifc.en = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({ifc.y_valid, ifc.done, ifc.load_ready} !== 3'b000) begin
        errors++;
        $display("FAIL pause_gap k=%0d got=%b exp=000", k,
          {ifc.y_valid, ifc.done, ifc.load_ready});
      end
    end
    ifc.en = 1;
    for (int k = 3; k < 11; k++) begin
      step();
      checks++;
      if ({ifc.y, ifc.y_valid, ifc.done} !==
          {dstr[k % ML], 1'b1, (k % ML) == ML - 1}) begin
        errors++;
        $display("FAIL pause_resume k=%0d got=%b exp=%b", k,
          {ifc.y, ifc.y_valid, ifc.done},
          {dstr[k % ML], 1'b1, (k % ML) == ML - 1});
      end
    end
  endtask

  task automatic test_load_in_run();
    do_reset();
    ifc.en = 1; ifc.mode = 1;
    step();
    ifc.load_valid = 1; ifc.load_pattern = 8'hFF; ifc.load_len = 4'd8;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if ({ifc.y, ifc.y_valid, ifc.done, ifc.load_ready} !==
          {exp_y, exp_v, exp_d, !m_run}) begin
        errors++;
        $display("FAIL load_in_run k=%0d got=%b exp=%b", k,
          {ifc.y, ifc.y_valid, ifc.done, ifc.load_ready},
          {exp_y, exp_v, exp_d, !m_run});
      end
      if (k == 8) ifc.load_valid = 0;
    end
    checks++;
    if ({ifc.y, ifc.y_valid} !== 2'b11) begin
      errors++;
      $display("FAIL load_after_idle got=%b exp=11", {ifc.y, ifc.y_valid});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ifc.en = 1; ifc.mode = 0;
    for (int k = 0; k < 5; k++) step();
    #2 reset = 0;
    #1;
    checks++;
    if ({ifc.y, ifc.y_valid, ifc.done, ifc.load_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid got=%b exp=0001",
        {ifc.y, ifc.y_valid, ifc.done, ifc.load_ready});
    end
    model_reset();
    @(negedge clk);
    reset = 1;
    step();
    checks++;
    if ({ifc.y, ifc.y_valid, ifc.done} !== {dstr[0], 2'b10}) begin
      errors++;
      $display("FAIL reset_restart got=%b exp=%b",
        {ifc.y, ifc.y_valid, ifc.done}, {dstr[0], 2'b10});
    end
  endtask

  task automatic test_len_edges();
    logic [3:0] lens [3];
    int ndone;
    lens[0] = 4'd0; lens[1] = 4'd9; lens[2] = 4'd1;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      ifc.load_valid = 1; ifc.en = 1;
      ifc.load_pattern = 8'($urandom); ifc.load_len = lens[t];
      step();
      ifc.load_valid = 0;
      ndone = 0;
      for (int k = 0; k < 16; k++) begin
        step();
        if (ifc.done) ndone++;
        checks++;
        if ({ifc.y, ifc.y_valid, ifc.done} !== {exp_y, exp_v, exp_d}) begin
          errors++;
          $display("FAIL len_edge len=%0d k=%0d got=%b exp=%b",
            lens[t], k, {ifc.y, ifc.y_valid, ifc.done},
            {exp_y, exp_v, exp_d});
        end
      end
      checks++;
      if (ndone !== ((t == 2) ? 16 : 2)) begin
        errors++;
        $display("FAIL len_edge_done len=%0d got=%0d exp=%0d",
          lens[t], ndone, (t == 2) ? 16 : 2);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if (k % 60 == 0) do_reset();
      ifc.en = ($urandom_range(0, 3) != 0);
      ifc.mode = ($urandom_range(0, 3) != 0);
      ifc.load_valid = ($urandom_range(0, 3) == 0);
      ifc.load_pattern = 8'($urandom);
      ifc.load_len = 4'($urandom_range(0, 15));
      step();
      checks++;
      if ({ifc.y, ifc.y_valid, ifc.done, ifc.load_ready} !==
          {exp_y, exp_v, exp_d, !m_run}) begin
        errors++;
        $display("FAIL random k=%0d got=%b exp=%b", k,
          {ifc.y, ifc.y_valid, ifc.done, ifc.load_ready},
          {exp_y, exp_v, exp_d, !m_run});
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_stream();
    test_oneshot_load();
    test_pause();
    test_load_in_run();
    test_reset_mid();
    test_len_edges();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, the maximum pattern length in bits (2..32).
REQ-002 SHALL have parameter DEFAULT_PATTERN, default 8'b1011_0010, the MAX_LEN-bit pattern loaded at reset.
REQ-003 SHALL have parameter LEN_W, default $clog2(MAX_LEN+1), the width of the length field.
REQ-004 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  advance enable; each high cycle emits one bit.
REQ-007 SHALL have port mode  input  1  0 = repeat, 1 = one-shot; sampled on the IDLE->RUN edge only.
REQ-008 SHALL have port load_valid  input  1  new-pattern request.
REQ-009 SHALL have port load_ready  output  1  pattern load accepted this cycle if load_valid.
REQ-010 SHALL have port load_pattern  input  MAX_LEN  new pattern, bit 0 emitted first.
REQ-011 SHALL have port load_len  input  LEN_W  new length; 0 or >MAX_LEN treated as MAX_LEN.
REQ-012 SHALL have port y  output  1  serial pattern bit, registered.
REQ-013 SHALL have port y_valid  output  1  y carries a pattern bit this cycle.
REQ-014 SHALL have port done  output  1  one-cycle pulse coincident with the last bit of a pass.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and PAUSE.
REQ-016 load_ready SHALL be 1 only in IDLE (combinational from state).
REQ-017 On a clock edge with load_valid && load_ready, pattern/len registers SHALL update; en is ignored that edge (load wins) and state stays IDLE.
REQ-018 IDLE, en=1, no load: y<=pattern[0], y_valid<=1, idx<=1, latched mode, go RUN (first bit visible the cycle after en sampled).
REQ-019 RUN, en=1: y<=pattern[idx], y_valid<=1, idx<=idx+1.
REQ-020 RUN or PAUSE, en=0: go/stay PAUSE, y_valid<=0, y and idx hold.
REQ-021 PAUSE, en=1: resume emission at held idx exactly as REQ-019; no bit skipped or repeated.
REQ-022 On the edge emitting bit len-1 (or bit 0 when len=1): done<=1 for one cycle.
REQ-023 At the end of a pass, repeat mode: idx wraps to 0 and next en cycle emits pattern[0] with no gap; one-shot: state<=IDLE, y_valid<=0 next cycle.
REQ-024 load_valid in RUN/PAUSE SHALL be ignored (no ready, no update); requester holds it until IDLE.
REQ-025 idx SHALL be LEN_W bits; must never address beyond len-1.
REQ-026 Mode change during RUN/PAUSE SHALL have no effect until the next IDLE->RUN start.
REQ-027 Repeat-mode runs SHALL return to IDLE only via reset.

Reset
REQ-028 reset low SHALL asynchronously force: state=IDLE, idx=0, pattern=DEFAULT_PATTERN, len=MAX_LEN, latched mode=repeat, y=0, y_valid=0, done=0.
REQ-029 Reset asserted mid-pass SHALL abort the pass with no done pulse; release resumes in IDLE with load_ready=1.

Structure
REQ-030 Package seq_pattern_gen_pkg SHALL hold the state enum (IDLE, RUN, PAUSE), the mode enum (REPEAT, ONE_SHOT) and the MAX_LEN default constant.
REQ-031 Bit-index counter with wrap and terminal-count flag SHALL be sub-module pattern_idx_counter; the rest stays in seq_pattern_gen.

Verification
REQ-032 Reset, en=1 continuous, mode=0 defaults -> y stream 0,1,0,0,1,1,0,1 repeating; done high with every 8th bit.
REQ-033 Load pattern 8'h05, len=3, mode=1, then en=1 -> y 1,0,1 with y_valid=1, done on 3rd bit, then y_valid=0, load_ready=1.
REQ-034 Repeat run, en low for 3 cycles after bit 2 -> y_valid=0 for 3 cycles, resumes with bit 3, no duplication.
REQ-035 load_valid during RUN with 8'hFF -> load_ready=0, stream unchanged; same request in IDLE with en=1 -> load taken, emission begins the following en cycle.
REQ-036 reset low after bit 4 of a pass -> y=0, y_valid=0, done=0 immediately (asynchronous); after release restarts at bit 0 of DEFAULT_PATTERN.
REQ-037 load_len=0 and load_len=MAX_LEN+1 -> both run full MAX_LEN-bit passes; len=1 -> done on every bit.
